// File: rtl/block_result_accumulator.sv
// rtl/block_result_accumulator.sv - element-wise accumulator for J x K partial-product tiles
// Sums N partial tiles in place, then drains the finished tile one element per beat.
module block_result_accumulator #(
  parameter int DATA_W       = 16,
  parameter int J            = 2,
  parameter int K            = 2,
  parameter int MAX_PARTIALS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(MAX_PARTIALS+1)-1:0]   cfg_num_partials,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W*J*K-1:0]               in_tile,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic [$clog2(J*K)-1:0]              out_index,
  output logic                                out_last,
  output logic [15:0]                         tile_count
);

  localparam int CNT_W = $clog2(MAX_PARTIALS + 1);
  localparam int N_EL  = J * K;
  localparam int IDX_W = $clog2(N_EL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EL - 1);

  typedef enum logic {S_ACCUM, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q [N_EL];
  logic [DATA_W-1:0] sum   [N_EL];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  nlat_q;
  logic [CNT_W-1:0]  n_cfg;
  logic [CNT_W-1:0]  n_eff;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic [15:0]       tile_count_q;
  logic [DATA_W-1:0] out_data_q;
  logic              accept;
  logic              last_partial;
  logic              out_fire;
  logic              drain_done;

  // Partial count as it applies to the tile in flight: live config only on its first partial.
  always_comb begin
    n_cfg = cfg_num_partials;
    if (cfg_num_partials == '0) begin
      n_cfg = CNT_W'(1);
    end else if (cfg_num_partials > CNT_W'(MAX_PARTIALS)) begin
      n_cfg = CNT_W'(MAX_PARTIALS);
    end
  end

  assign n_eff        = (cnt_q == '0) ? n_cfg : nlat_q;
  assign accept       = (state_q == S_ACCUM) && in_valid;
  assign last_partial = ((cnt_q + CNT_W'(1)) == n_eff);
  assign out_fire     = (state_q == S_DRAIN) && out_ready;
  assign drain_done   = out_fire && (idx_q == LAST_IDX);
  assign idx_nxt      = idx_q + IDX_W'(1);

  // The first partial of a tile overwrites rather than adds, so no clear is needed on exit.
  always_comb begin
    for (int e = 0; e < N_EL; e++) begin
      sum[e] = ((cnt_q == '0) ? '0 : acc_q[e]) + in_tile[e*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: if (accept && last_partial) state_d = S_DRAIN;
      S_DRAIN: if (drain_done)             state_d = S_ACCUM;
      default:                             state_d = S_ACCUM;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == S_ACCUM);
    out_valid  = (state_q == S_DRAIN);
    out_last   = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
    out_data   = out_data_q;
    out_index  = idx_q;
    tile_count = tile_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < N_EL; e++) begin
        acc_q[e] <= '0;
      end
      cnt_q        <= '0;
      nlat_q       <= '0;
      idx_q        <= '0;
      tile_count_q <= '0;
      out_data_q   <= '0;
    end else begin
      if (accept) begin
        for (int e = 0; e < N_EL; e++) begin
          acc_q[e] <= sum[e];
        end
        if (cnt_q == '0) begin
          nlat_q <= n_cfg;
        end
        if (last_partial) begin
          cnt_q      <= '0;
          idx_q      <= '0;
          out_data_q <= sum[0];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      // out_data is staged one element ahead so the port comes straight from a flop.
      if (out_fire) begin
        if (idx_q == LAST_IDX) begin
          tile_count_q <= tile_count_q + 16'd1;
          idx_q        <= '0;
          out_data_q   <= '0;
        end else begin
          idx_q      <= idx_nxt;
          out_data_q <= acc_q[idx_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_block_result_accumulator.sv
// tb/tb_block_result_accumulator.sv - directed table-driven bench for block_result_accumulator
// Vectors carry partial tiles and hand-computed drained tiles; corner cases are hand sequences.
module tb_block_result_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_num_partials;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_tile;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic [15:0] tile_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_tc    = 0;

  block_result_accumulator #(
    .DATA_W(16), .J(2), .K(2), .MAX_PARTIALS(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_num_partials(cfg_num_partials),
    .in_valid(in_valid), .in_ready(in_ready), .in_tile(in_tile),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  cfg;
    logic [1:0]  np;
    logic        idle2;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [63:0] p2;
    logic [63:0] exp_t;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [63:0] mk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] tile);
    int n;
    in_tile  = tile;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [63:0] exp_t, input int start);
    int n;
    out_ready = 1'b1;
    for (int b = start; b < 4; b++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        n++;
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(exp_t[b*16 +: 16]));
      check("out_index", 32'(out_index), 32'(b));
      check("out_last", 32'(out_last), (b == 3) ? 32'd1 : 32'd0);
      step();
    end
    exp_tc++;
    check("tile_count", 32'(tile_count), 32'(exp_tc));
    check("in_ready_after_drain", 32'(in_ready), 32'd1);
    check("out_valid_after_drain", 32'(out_valid), 32'd0);
  endtask

  task automatic check_idle_outputs();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_last", 32'(out_last), 32'd0);
    check("idle_out_index", 32'(out_index), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);
    check("idle_tile_count", 32'(tile_count), 32'(exp_tc));
  endtask

  initial begin
    vecs[0] = '{cfg: 5'd1, np: 2'd1, idle2: 1'b0, p0: mk(1, 2, 3, 4), p1: '0, p2: '0,
                exp_t: mk(1, 2, 3, 4)};
    vecs[1] = '{cfg: 5'd3, np: 2'd3, idle2: 1'b1, p0: mk(1, 1, 1, 1), p1: mk(2, 0, 2, 0),
                p2: mk(10, 20, 30, 40), exp_t: mk(13, 21, 33, 41)};
    vecs[2] = '{cfg: 5'd2, np: 2'd2, idle2: 1'b0, p0: mk(16'h7FFF, 16'hFFFF, 16'h8000, 16'd5),
                p1: mk(16'd1, 16'd1, 16'h8000, 16'hFFFB), p2: '0,
                exp_t: mk(16'h8000, 16'h0000, 16'h0000, 16'h0000)};
    vecs[3] = '{cfg: 5'd0, np: 2'd1, idle2: 1'b0, p0: mk(3, 4, 5, 6), p1: '0, p2: '0,
                exp_t: mk(3, 4, 5, 6)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tile = '0; cfg_num_partials = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs();

    for (int i = 0; i < 4; i++) begin
      cfg_num_partials = vecs[i].cfg;
      out_ready = 1'b1;
      for (int p = 0; p < int'(vecs[i].np); p++) begin
        send((p == 0) ? vecs[i].p0 : (p == 1) ? vecs[i].p1 : vecs[i].p2);
        if (p == 1 && vecs[i].idle2) begin
          step();
          check("ready_after_idle", 32'(in_ready), 32'd1);
        end
        if (p < int'(vecs[i].np) - 1) begin
          check("in_ready_mid_tile", 32'(in_ready), 32'd1);
          check("out_valid_mid_tile", 32'(out_valid), 32'd0);
        end else begin
          check("in_ready_after_final", 32'(in_ready), 32'd0);
          check("out_valid_after_final", 32'(out_valid), 32'd1);
        end
      end
      drain(vecs[i].exp_t, 0);
    end

    // Backpressure on index 1 with a rejected tile offered during drain.
    cfg_num_partials = 5'd1;
    out_ready = 1'b1;
    send(mk(9, 8, 7, 6));
    check("bp_beat0_data", 32'(out_data), 32'd9);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tile   = mk(100, 100, 100, 100);
    repeat (3) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'd8);
      check("bp_hold_index", 32'(out_index), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain(mk(9, 8, 7, 6), 1);
    send(mk(1, 1, 1, 1));
    drain(mk(1, 1, 1, 1), 0);

    // Config change after first accept does not affect the tile in flight.
    cfg_num_partials = 5'd2;
    send(mk(1, 2, 3, 4));
    cfg_num_partials = 5'd1;
    check("cfg_change_ready", 32'(in_ready), 32'd1);
    send(mk(1, 1, 1, 1));
    drain(mk(2, 3, 4, 5), 0);

    // Oversized config clamps to 16 partials.
    cfg_num_partials = 5'd31;
    for (int p = 0; p < 16; p++) begin
      send(mk(1, 2, 3, 4));
      if (p == 14) check("clamp_ready_15", 32'(in_ready), 32'd1);
      if (p == 15) check("clamp_ready_16", 32'(in_ready), 32'd0);
    end
    drain(mk(16, 32, 48, 64), 0);

    // Reset part-way through a tile discards everything.
    cfg_num_partials = 5'd3;
    send(mk(7, 7, 7, 7));
    send(mk(7, 7, 7, 7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_tc = 0;
    check_idle_outputs();
    cfg_num_partials = 5'd1;
    send(mk(5, 5, 5, 5));
    drain(mk(5, 5, 5, 5), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
